// File: rtl/freelist_ctrl_pkg.sv
// Shared sizing constants and small helpers for the rename-stage physical register free list.
package freelist_ctrl_pkg;

    localparam int DEF_NUM_PREG        = 64;
    localparam int DEF_NUM_LREG        = 32;
    localparam int DEF_PREG_W          = $clog2(DEF_NUM_PREG);
    localparam int DEF_LREG_W          = $clog2(DEF_NUM_LREG);
    localparam int FREELIST_DEPTH      = DEF_NUM_PREG - DEF_NUM_LREG;
    localparam int FREELIST_PTR_W      = $clog2(FREELIST_DEPTH) + 1;

    typedef logic [DEF_PREG_W-1:0]     preg_t;
    typedef logic [DEF_LREG_W-1:0]     lreg_t;
    typedef logic [FREELIST_PTR_W-1:0] freelist_ptr_t;

    // Population count of two request/release strobes.
    function automatic logic [1:0] count2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/freelist_ram.sv
// Free-list storage: DEPTH entries, two synchronous write ports (port 1 wins on a shared
// address) and two asynchronous read ports.
module freelist_ram
#(
    parameter int  DEPTH    = 32,
    parameter int  PREG_W   = 6,
    parameter int  NUM_LREG = 32,
    localparam int IDX_W    = $clog2(DEPTH)
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              we0,
    input  logic [IDX_W-1:0]  waddr0,
    input  logic [PREG_W-1:0] wdata0,
    input  logic              we1,
    input  logic [IDX_W-1:0]  waddr1,
    input  logic [PREG_W-1:0] wdata1,
    input  logic [IDX_W-1:0]  raddr0,
    output logic [PREG_W-1:0] rdata0,
    input  logic [IDX_W-1:0]  raddr1,
    output logic [PREG_W-1:0] rdata1
);

    logic [PREG_W-1:0] mem [DEPTH];

    // NOTE: the array is reset because its contents are the initial free list
    // (PREGs above the architectural mapping), not scratch data.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PREG_W'(NUM_LREG + i);
            end
        end else begin
            if (we0) mem[waddr0] <= wdata0;
            if (we1) mem[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/freelist_ctrl.sv
// Physical register free list: up to two allocations to rename and two reclaims from commit
// per cycle, with flush restoring the speculative head to the committed head.
module freelist_ctrl
    import freelist_ctrl_pkg::*;
#(
    parameter int  NUM_PREG = DEF_NUM_PREG,
    parameter int  NUM_LREG = DEF_NUM_LREG,
    parameter int  DEPTH    = NUM_PREG - NUM_LREG,
    localparam int PREG_W   = $clog2(NUM_PREG),
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int PTR_W    = IDX_W + 1
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              instr0_freelist_req,
    output logic [PREG_W-1:0] instr0_freelist_resp,
    input  logic              instr1_freelist_req,
    output logic [PREG_W-1:0] instr1_freelist_resp,
    output logic              freelist_can_alloc,
    output logic [PTR_W-1:0]  free_count,
    input  logic              commit0_valid,
    input  logic              commit0_need_to_wb,
    input  logic [PREG_W-1:0] commit0_old_prd,
    input  logic              commit1_valid,
    input  logic              commit1_need_to_wb,
    input  logic [PREG_W-1:0] commit1_old_prd,
    input  logic              flush_valid
);

    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);

    logic [PTR_W-1:0]  spec_head, arch_head, tail;
    logic [PTR_W-1:0]  spec_head_next, arch_head_next, tail_next;
    logic [1:0]        n_alloc, n_rel;
    logic              rel0, rel1;

    logic              we0, we1;
    logic [IDX_W-1:0]  waddr0, waddr1, raddr0, raddr1;
    logic [PREG_W-1:0] wdata0, wdata1, rdata0, rdata1;

    assign rel0    = commit0_valid & commit0_need_to_wb;
    assign rel1    = commit1_valid & commit1_need_to_wb;
    assign n_rel   = count2(rel0, rel1);
    assign n_alloc = flush_valid ? 2'd0 : count2(instr0_freelist_req, instr1_freelist_req);

    // Releases are packed at tail in commit order, so a lone slot-1 release lands at tail.
    assign we0    = rel0 | rel1;
    assign waddr0 = tail[IDX_W-1:0];
    assign wdata0 = rel0 ? commit0_old_prd : commit1_old_prd;
    assign we1    = rel0 & rel1;
    assign waddr1 = tail[IDX_W-1:0] + IDX_W'(1);
    assign wdata1 = commit1_old_prd;

    assign raddr0 = spec_head[IDX_W-1:0];
    assign raddr1 = spec_head[IDX_W-1:0] + IDX_W'(1);

    freelist_ram #(
        .DEPTH    (DEPTH),
        .PREG_W   (PREG_W),
        .NUM_LREG (NUM_LREG)
    ) u_ram (
        .clock  (clock),
        .reset  (reset),
        .we0    (we0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .raddr0 (raddr0),
        .rdata0 (rdata0),
        .raddr1 (raddr1),
        .rdata1 (rdata1)
    );

    // Slot 1 takes the next entry only when slot 0 is also consuming one.
    assign instr0_freelist_resp = rdata0;
    assign instr1_freelist_resp = instr0_freelist_req ? rdata1 : rdata0;

    // NOTE: every variable gets its value before any conditional override, so no latch is inferred.
    always_comb begin
        arch_head_next = arch_head + PTR_W'(n_rel);
        tail_next      = tail + PTR_W'(n_rel);
        spec_head_next = spec_head + PTR_W'(n_alloc);
        if (flush_valid) begin
            spec_head_next = arch_head_next;
        end
    end

    // NOTE: non-blocking assignments so each pointer update sees only pre-edge state.
    always_ff @(posedge clock) begin
        if (reset) begin
            spec_head <= '0;
            arch_head <= '0;
            tail      <= DEPTH_PTR;
        end else begin
            spec_head <= spec_head_next;
            arch_head <= arch_head_next;
            tail      <= tail_next;
        end
    end

    assign free_count         = tail - spec_head;
    assign freelist_can_alloc = free_count >= PTR_W'(2);

    logic [PTR_W-1:0] req_cnt;
    assign req_cnt = PTR_W'(count2(instr0_freelist_req, instr1_freelist_req));

    a_no_over_alloc: assert property (@(posedge clock) disable iff (reset)
        !flush_valid |-> req_cnt <= free_count);

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        (tail - arch_head) <= DEPTH_PTR);

    a_arch_behind_spec: assert property (@(posedge clock) disable iff (reset)
        (spec_head - arch_head) <= DEPTH_PTR);

endmodule

// File: tb/tb_freelist_ctrl.sv
// Self-checking bench for freelist_ctrl: directed scenarios plus randomized legal traffic,
// compared every cycle against a queue-based model of the free list.
module tb_freelist_ctrl;

    localparam int NUM_PREG = 64;
    localparam int NUM_LREG = 32;
    localparam int DEPTH    = NUM_PREG - NUM_LREG;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [5:0] resp0, resp1;
    logic       can_alloc;
    logic [5:0] free_count;
    logic       c0v, c0w, c1v, c1w;
    logic [5:0] c0p, c1p;
    logic       flush;

    int n_checks = 0;
    int n_err    = 0;

    // Model: fl holds the committed free list in order (arch_head .. tail);
    // the first 'inflight' entries are speculatively allocated.
    int fl[$];
    int inflight   = 0;
    bit model_valid = 0;

    always #5 clock = ~clock;

    freelist_ctrl #(
        .NUM_PREG (NUM_PREG),
        .NUM_LREG (NUM_LREG),
        .DEPTH    (DEPTH)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .instr0_freelist_req  (req0),
        .instr0_freelist_resp (resp0),
        .instr1_freelist_req  (req1),
        .instr1_freelist_resp (resp1),
        .freelist_can_alloc   (can_alloc),
        .free_count           (free_count),
        .commit0_valid        (c0v),
        .commit0_need_to_wb   (c0w),
        .commit0_old_prd      (c0p),
        .commit1_valid        (c1v),
        .commit1_need_to_wb   (c1w),
        .commit1_old_prd      (c1p),
        .flush_valid          (flush)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        req0 = 0; req1 = 0;
        c0v = 0; c0w = 0; c0p = '0;
        c1v = 0; c1w = 0; c1p = '0;
        flush = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Model update on each active edge, from pre-edge inputs.
    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                fl = {};
                for (int i = 0; i < DEPTH; i++) fl.push_back(NUM_LREG + i);
                inflight    = 0;
                model_valid = 1;
            end else if (model_valid) begin
                int nrel, nalloc;
                nrel   = int'(c0v && c0w) + int'(c1v && c1w);
                nalloc = flush ? 0 : int'(req0) + int'(req1);
                for (int i = 0; i < nrel; i++) void'(fl.pop_front());
                if (c0v && c0w) fl.push_back(int'(c0p));
                if (c1v && c1w) fl.push_back(int'(c1p));
                inflight = flush ? 0 : inflight + nalloc - nrel;
            end
        end
    end

    // Compare process: checks outputs on the falling edge whenever the model is meaningful.
    initial begin
        forever begin
            @(negedge clock);
            if (model_valid && !reset) begin
                int fc;
                fc = fl.size() - inflight;
                check("free_count", 32'(free_count), 32'(fc));
                check("can_alloc", 32'(can_alloc), 32'(fc >= 2));
                if (fc >= 1) check("resp0", 32'(resp0), 32'(fl[inflight]));
                if (fc >= 2 && req0) check("resp1", 32'(resp1), 32'(fl[inflight+1]));
                if (fc >= 1 && !req0) check("resp1_same", 32'(resp1), 32'(fl[inflight]));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1;
        idle();
        repeat (2) @(posedge clock);
        #1;

        // Reset state (reset still high, so req0 cannot advance anything).
        req0 = 1; #1;
        check("rst_resp0", 32'(resp0), 32);
        check("rst_resp1", 32'(resp1), 33);
        check("rst_count", 32'(free_count), 32);
        check("rst_can", 32'(can_alloc), 1);
        req0 = 0;
        reset = 0;
        tick();
        check("idle_resp0", 32'(resp0), 32);
        check("idle_count", 32'(free_count), 32);

        // Dual allocation drains the list in order.
        for (int k = 0; k < 15; k++) begin
            req0 = 1; req1 = 1; #1;
            check("dual_resp0", 32'(resp0), 32'(32 + 2*k));
            check("dual_resp1", 32'(resp1), 32'(33 + 2*k));
            tick();
        end
        idle(); #1;
        check("two_left_count", 32'(free_count), 2);
        check("two_left_can", 32'(can_alloc), 1);
        req0 = 1; #1;
        check("single_resp0", 32'(resp0), 62);
        tick();
        idle(); #1;
        check("one_left_count", 32'(free_count), 1);
        check("one_left_can", 32'(can_alloc), 0);
        req0 = 1; #1;
        check("last_resp0", 32'(resp0), 63);
        tick();
        idle(); #1;
        check("empty_count", 32'(free_count), 0);

        // Two releases in one cycle become visible next cycle.
        c0v = 1; c0w = 1; c0p = 6'd5;
        c1v = 1; c1w = 1; c1p = 6'd9;
        tick();
        idle(); req0 = 1; #1;
        check("rel_resp0", 32'(resp0), 5);
        check("rel_resp1", 32'(resp1), 9);
        check("rel_count", 32'(free_count), 2);
        req0 = 0;

        // Slot-1-only release after the tail has wrapped to index 0.
        reset = 1; tick(); reset = 0;
        for (int k = 0; k < 16; k++) begin
            req0 = 1; req1 = 1; tick();
        end
        idle(); #1;
        check("drain_count", 32'(free_count), 0);
        c0v = 1; c0w = 0; c0p = 6'd3;
        c1v = 1; c1w = 1; c1p = 6'd12;
        tick();
        idle(); #1;
        check("wrap_resp0", 32'(resp0), 12);
        check("wrap_count", 32'(free_count), 1);
        c0v = 1; c0w = 1; c0p = 6'd20;
        tick();
        idle(); req0 = 1; #1;
        check("wrap_next_resp1", 32'(resp1), 20);
        check("wrap_next_count", 32'(free_count), 2);
        req0 = 0;

        // Flush with a same-cycle commit; allocation requests in that cycle are ignored.
        reset = 1; tick(); reset = 0;
        req0 = 1; req1 = 1; tick();
        req0 = 1; req1 = 1; tick();
        idle();
        req0 = 1; req1 = 1;
        c0v = 1; c0w = 1; c0p = 6'd7;
        flush = 1;
        tick();
        idle(); #1;
        check("flush_resp0", 32'(resp0), 33);
        check("flush_count", 32'(free_count), 32);
        req0 = 1; #1;
        check("flush_resp1", 32'(resp1), 34);
        req0 = 0;

        // Reset overrides simultaneous alloc, release and flush.
        req0 = 1; req1 = 1; tick();
        reset = 1;
        req0 = 1; req1 = 1;
        c0v = 1; c0w = 1; c0p = 6'd40;
        c1v = 1; c1w = 1; c1p = 6'd41;
        flush = 1;
        tick();
        reset = 0;
        idle(); #1;
        check("midrst_resp0", 32'(resp0), 32);
        check("midrst_count", 32'(free_count), 32);
        check("midrst_can", 32'(can_alloc), 1);
        req0 = 1; #1;
        check("midrst_resp1", 32'(resp1), 33);
        req0 = 0;
        tick();

        // Randomized legal traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int fc, pat, nrel;
            idle();
            if (!reset && $urandom_range(599) == 0) begin
                reset = 1;
            end else begin
                reset = 0;
                fc    = fl.size() - inflight;
                flush = ($urandom_range(15) == 0);
                pat   = $urandom_range(3);
                if (!flush) begin
                    if (fc == 0) pat = 0;
                    else if (fc == 1 && pat == 3) pat = 1 + $urandom_range(1);
                end
                req0 = pat[0];
                req1 = pat[1];
                c0v = $urandom_range(1); c0w = $urandom_range(1); c0p = 6'($urandom_range(63));
                c1v = $urandom_range(1); c1w = $urandom_range(1); c1p = 6'($urandom_range(63));
                nrel = int'(c0v && c0w) + int'(c1v && c1w);
                if (nrel > inflight) begin
                    c1w  = 0;
                    nrel = int'(c0v && c0w);
                end
                if (nrel > inflight) c0w = 0;
            end
            tick();
        end
        reset = 0;
        idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
